// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the load alignment unit: RV32I load funct3 codes,
// FSM state encoding and alignment helpers.
package load_align_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT0 = 2'b01,
        ST_WAIT1 = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_LH) || (f3 == F3_LHU);
    endfunction

    // Natural alignment: halfwords on even addresses, words on multiples of 4.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (is_half(f3) && off[0]) || ((f3 == F3_LW) && (off != 2'b00));
    endfunction

    // Only accesses that cross into the next word need a second read.
    function automatic logic needs_split(input logic [2:0] f3, input logic [1:0] off);
        return (is_half(f3) && (off == 2'b11)) || ((f3 == F3_LW) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational extractor: picks the byte/half/word at the byte offset from the
// little-endian pair {word1, word0} and sign- or zero-extends it.
module load_extend
    import load_align_unit_pkg::*;
(
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = 32'({word1, word0} >> {offset, 3'b000});

    always_comb begin
        data = '0;
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   data = shifted;
            F3_LBU:  data = {24'd0, shifted[7:0]};
            F3_LHU:  data = {16'd0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load unit: fetches one or two aligned words over a valid/ack read
// port, extracts and extends the addressed datum, returns it over valid/ready.
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [31:0]       mem_rd_data,
    output logic              load_valid,
    input  logic              load_ready,
    output logic [31:0]       load_data,
    output logic              load_err
);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [2:0]          funct3_reg, funct3_next;
    logic [31:0]         word0_reg, word0_next;
    logic [31:0]         load_data_reg, load_data_next;
    logic                load_err_reg, load_err_next;

    logic [1:0]          offset;
    logic [ADDR_W-1:0]   word_addr;
    logic [ADDR_W-1:0]   word_addr_hi;
    logic [31:0]         ext_word0, ext_word1, ext_data;

    assign offset       = addr_reg[1:0];
    assign word_addr    = {addr_reg[ADDR_W-1:2], 2'b00};
    // Natural wrap at the top of the address space is intended.
    assign word_addr_hi = word_addr + ADDR_W'(4);

    // Feed the extractor straight from the bus on the beat that completes the load.
    assign ext_word0 = (state_reg == ST_WAIT0) ? mem_rd_data : word0_reg;
    assign ext_word1 = (state_reg == ST_WAIT1) ? mem_rd_data : 32'd0;

    load_extend u_extend (
        .word0  (ext_word0),
        .word1  (ext_word1),
        .offset (offset),
        .funct3 (funct3_reg),
        .data   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            funct3_reg    <= '0;
            word0_reg     <= '0;
            load_data_reg <= '0;
            load_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            funct3_reg    <= funct3_next;
            word0_reg     <= word0_next;
            load_data_reg <= load_data_next;
            load_err_reg  <= load_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        funct3_next    = funct3_reg;
        word0_next     = word0_reg;
        load_data_next = load_data_reg;
        load_err_next  = load_err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_next      = req_addr;
                    funct3_next    = req_funct3;
                    load_data_next = '0;
                    if (!f3_legal(req_funct3) ||
                        (!SPLIT_MISALIGNED && misaligned(req_funct3, req_addr[1:0]))) begin
                        load_err_next = 1'b1;
                        state_next    = ST_RESP;
                    end else begin
                        load_err_next = 1'b0;
                        state_next    = ST_WAIT0;
                    end
                end
            end
            ST_WAIT0: begin
                if (mem_rd_valid) begin
                    word0_next = mem_rd_data;
                    if (needs_split(funct3_reg, offset)) begin
                        state_next = ST_WAIT1;
                    end else begin
                        load_data_next = ext_data;
                        state_next     = ST_RESP;
                    end
                end
            end
            ST_WAIT1: begin
                if (mem_rd_valid) begin
                    load_data_next = ext_data;
                    state_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (load_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign req_ready  = (state_reg == ST_IDLE);
    assign mem_rd_en  = (state_reg == ST_WAIT0) || (state_reg == ST_WAIT1);
    assign mem_addr   = (state_reg == ST_WAIT0) ? word_addr :
                        (state_reg == ST_WAIT1) ? word_addr_hi : '0;
    assign load_valid = (state_reg == ST_RESP);
    assign load_data  = load_data_reg;
    assign load_err   = load_err_reg;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: directed loads against a small memory
// model, plus a second instance built without misaligned splitting.
module tb_load_align_unit;
    import load_align_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic        mem_rd_en, mem_rd_valid = 1'b0;
    logic [31:0] mem_addr, mem_rd_data = '0;
    logic        load_valid, load_ready = 1'b1, load_err;
    logic [31:0] load_data;

    logic        req_valid_ns = 1'b0, req_ready_ns;
    logic [31:0] req_addr_ns = '0;
    logic [2:0]  req_funct3_ns = '0;
    logic        mem_rd_en_ns, mem_rd_valid_ns = 1'b0;
    logic [31:0] mem_addr_ns, mem_rd_data_ns = '0;
    logic        load_valid_ns, load_ready_ns = 1'b0, load_err_ns;
    logic [31:0] load_data_ns;

    load_align_unit #(.SPLIT_MISALIGNED(1'b1), .ADDR_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_err(load_err)
    );

    load_align_unit #(.SPLIT_MISALIGNED(1'b0), .ADDR_W(32)) u_dut_ns (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_ns), .req_ready(req_ready_ns),
        .req_addr(req_addr_ns), .req_funct3(req_funct3_ns),
        .mem_rd_en(mem_rd_en_ns), .mem_addr(mem_addr_ns),
        .mem_rd_valid(mem_rd_valid_ns), .mem_rd_data(mem_rd_data_ns),
        .load_valid(load_valid_ns), .load_ready(load_ready_ns),
        .load_data(load_data_ns), .load_err(load_err_ns)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h8844_22F1;
            32'h0000_0104: return 32'h1122_3344;
            32'hFFFF_FFFC: return 32'hAABB_CCDD;
            32'h0000_0000: return 32'h0000_0077;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          nrd;
        logic [31:0] a0;
        logic [31:0] a1;
        int          hold;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_log[$];

    // Memory model: optional stall cycles per read, logs every acknowledged address.
    int          mem_wait = 0;
    int          stall_cnt = 0;
    bit          stale_mode = 1'b0;
    logic [31:0] stall_addr = '0;
    always @(negedge clk) begin
        if (stale_mode) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hCAFE_F00D;
        end else if (mem_rd_en) begin
            if (stall_cnt < mem_wait) begin
                if (stall_cnt == 0) stall_addr = mem_addr;
                else check("mem_addr_stable", mem_addr, stall_addr);
                stall_cnt++;
                mem_rd_valid = 1'b0;
            end else begin
                if (stall_cnt > 0) check("mem_addr_stable", mem_addr, stall_addr);
                mem_rd_valid = 1'b1;
                mem_rd_data  = mem_read(mem_addr);
                rd_log.push_back(mem_addr);
                stall_cnt = 0;
            end
        end else begin
            mem_rd_valid = 1'b0;
            stall_cnt = 0;
        end
    end

    bit ns_rd_seen = 1'b0;
    always @(negedge clk) if (mem_rd_en_ns) ns_rd_seen = 1'b1;

    // Monitor: pops an expectation on every new response and drives consumer backpressure.
    initial begin
        int          accept_cyc = 0;
        bit          in_resp = 1'b0;
        int          hold_left = 0;
        logic [31:0] held_data = '0;
        logic        held_err = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                accept_cyc = cyc;
                rd_log.delete();
            end
            if (load_valid) begin
                if (!in_resp) begin
                    in_resp = 1'b1;
                    held_data = load_data;
                    held_err = load_err;
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_response: got data 0x%08h err %0b, required no response",
                                 load_data, load_err);
                        hold_left = 0;
                    end else begin
                        e = exp_q.pop_front();
                        $display("load addr=0x%08h data=0x%08h err=%0b lat=%0d reads=%0d",
                                 e.addr, load_data, load_err, cyc - accept_cyc, rd_log.size());
                        check("load_data", load_data, e.data);
                        check("load_err", 32'(load_err), 32'(e.err));
                        check("latency", cyc - accept_cyc, e.lat);
                        check("n_reads", rd_log.size(), e.nrd);
                        if (e.nrd > 0 && rd_log.size() > 0) check("read_addr0", rd_log[0], e.a0);
                        if (e.nrd > 1 && rd_log.size() > 1) check("read_addr1", rd_log[1], e.a1);
                        hold_left = e.hold;
                    end
                end else begin
                    check("hold_data", load_data, held_data);
                    check("hold_err", 32'(load_err), 32'(held_err));
                    check("hold_req_ready", 32'(req_ready), 32'd0);
                end
                if (hold_left > 0) begin
                    load_ready = 1'b0;
                    hold_left--;
                end else begin
                    load_ready = 1'b1;
                end
                if (load_ready) in_resp = 1'b0;
            end else begin
                in_resp = 1'b0;
                load_ready = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            total_cnt++;
            $display("FAIL idle_timeout: got req_ready 0, required 1 within 200 cycles");
        end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                           input logic err, input int lat, input int nrd,
                           input logic [31:0] a0, input logic [31:0] a1, input int hold);
        exp_t e;
        wait_idle();
        e.addr = a; e.data = d; e.err = err; e.lat = lat;
        e.nrd = nrd; e.a0 = a0; e.a1 = a1; e.hold = hold;
        exp_q.push_back(e);
        req_valid = 1'b1; req_addr = a; req_funct3 = f3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        rst_n = 1'b1;

        do_load(32'h100, F3_LB,  32'hFFFF_FFF1, 0, 2, 1, 32'h100, 32'h0, 0);
        do_load(32'h103, F3_LBU, 32'h0000_0088, 0, 2, 1, 32'h100, 32'h0, 0);
        do_load(32'h102, F3_LH,  32'hFFFF_8844, 0, 2, 1, 32'h100, 32'h0, 0);
        do_load(32'h102, F3_LHU, 32'h0000_8844, 0, 2, 1, 32'h100, 32'h0, 0);
        do_load(32'h100, F3_LW,  32'h8844_22F1, 0, 2, 1, 32'h100, 32'h0, 0);
        do_load(32'h101, F3_LHU, 32'h0000_4422, 0, 2, 1, 32'h100, 32'h0, 0);
        do_load(32'h101, F3_LW,  32'h4488_4422, 0, 3, 2, 32'h100, 32'h104, 0);
        do_load(32'h103, F3_LH,  32'h0000_4488, 0, 3, 2, 32'h100, 32'h104, 0);
        do_load(32'hFFFF_FFFE, F3_LW, 32'h0077_AABB, 0, 3, 2, 32'hFFFF_FFFC, 32'h0, 0);
        do_load(32'h100, 3'b011, 32'h0, 1, 1, 0, 32'h0, 32'h0, 0);
        do_load(32'h104, 3'b110, 32'h0, 1, 1, 0, 32'h0, 32'h0, 2);
        mem_wait = 3;
        do_load(32'h104, F3_LW,  32'h1122_3344, 0, 5, 1, 32'h104, 32'h0, 0);
        mem_wait = 0;
        do_load(32'h101, F3_LBU, 32'h0000_0022, 0, 2, 1, 32'h100, 32'h0, 4);

        // Reset in the middle of the second beat of a split load.
        wait_idle();
        mem_wait = 3;
        req_valid = 1'b1; req_addr = 32'h101; req_funct3 = F3_LW;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!(mem_rd_en && mem_addr == 32'h104) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_wait1_addr", mem_addr, 32'h104);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_wait = 0;
        check("midrst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("midrst_load_valid", 32'(load_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_load_data", load_data, 32'd0);
        stale_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stale_load_valid", 32'(load_valid), 32'd0);
            check("stale_mem_rd_en", 32'(mem_rd_en), 32'd0);
        end
        stale_mode = 1'b0;

        // Instance without splitting: misaligned LW is an error with no memory access.
        @(posedge clk); #1;
        req_valid_ns = 1'b1; req_addr_ns = 32'h101; req_funct3_ns = F3_LW;
        @(posedge clk); #1;
        req_valid_ns = 1'b0;
        $display("load_ns addr=0x00000101 data=0x%08h err=%0b valid=%0b",
                 load_data_ns, load_err_ns, load_valid_ns);
        check("ns_load_valid_lat1", 32'(load_valid_ns), 32'd1);
        check("ns_load_err", 32'(load_err_ns), 32'd1);
        check("ns_load_data", load_data_ns, 32'd0);
        load_ready_ns = 1'b1;
        @(posedge clk); #1;
        load_ready_ns = 1'b0;
        check("ns_back_idle", 32'(req_ready_ns), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("ns_no_read", 32'(ns_rd_seen), 32'd0);

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, required finish within 200us");
        $fatal(1, "timeout");
    end

endmodule
